// File: rtl/matrix_loader_if.sv
// -----------------------------------------------------------------------------
// matrix_loader_if
// Groups the loader's control handshake, operand stream, X/Y memory write ports
// and multiplier handshake into one bundle. Clock and reset stay plain ports on
// the modules that use this interface.
//
// Signals
//   load_start  request to load one X/Y operand pair and run the multiplier
//   busy        loader is not idle
//   done        one-cycle completion pulse
//   in_data     streamed operand word
//   in_valid    in_data is valid
//   in_ready    loader accepts in_data this cycle
//   x_din/x_addr/x_wr_en   X memory write port
//   y_din/y_addr/y_wr_en   Y memory write port
//   mm_start    start pulse to the downstream multiplier
//   mm_done     completion flag from the downstream multiplier
//
// Modports
//   slave   the loader itself
//   master  whatever drives the loader (controller, stream source, memories,
//           multiplier model)
// -----------------------------------------------------------------------------
interface matrix_loader_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6
);
    logic                  load_start;
    logic                  busy;
    logic                  done;

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;

    logic [DATA_WIDTH-1:0] x_din;
    logic [ADDR_WIDTH-1:0] x_addr;
    logic                  x_wr_en;

    logic [DATA_WIDTH-1:0] y_din;
    logic [ADDR_WIDTH-1:0] y_addr;
    logic                  y_wr_en;

    logic                  mm_start;
    logic                  mm_done;

    modport slave (
        input  load_start,
        input  in_data,
        input  in_valid,
        input  mm_done,
        output busy,
        output done,
        output in_ready,
        output x_din,
        output x_addr,
        output x_wr_en,
        output y_din,
        output y_addr,
        output y_wr_en,
        output mm_start
    );

    modport master (
        output load_start,
        output in_data,
        output in_valid,
        output mm_done,
        input  busy,
        input  done,
        input  in_ready,
        input  x_din,
        input  x_addr,
        input  x_wr_en,
        input  y_din,
        input  y_addr,
        input  y_wr_en,
        input  mm_start
    );
endinterface

// File: rtl/matrix_loader.sv
// -----------------------------------------------------------------------------
// matrix_loader
// Streams one Tn x Tn X operand followed by one Tn x Tn Y operand (row-major,
// valid/ready handshake) into the X and Y write ports, then pulses mm_start,
// waits for mm_done and reports completion with a one-cycle done pulse.
//
// Ports
//   clock   single clock, rising edge
//   reset   asynchronous, active-high; forces IDLE and all outputs low
//   bus     matrix_loader_if.slave (handshake, stream, X/Y write, multiplier)
//
// Build option
//   MATRIX_LOADER_TRANSPOSE_Y_EN  when defined, Y word (r, c) is written to
//   address c*Tn + r (Y stored transposed); otherwise Y uses the linear element
//   index. X addressing is linear in both builds.
//
// State table
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   IDLE     | waiting for load_start; all outputs low
//   LOAD_X   | accepting Tn*Tn words into X memory
//   LOAD_Y   | accepting Tn*Tn words into Y memory
//   START    | one-cycle mm_start pulse
//   WAIT     | waiting for mm_done
//   DONE     | one-cycle done pulse, then back to IDLE
// -----------------------------------------------------------------------------
module matrix_loader #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 6,
    parameter int Tn         = 8
) (
    input  logic            clock,
    input  logic            reset,
    matrix_loader_if.slave  bus
);

    if (Tn * Tn > (1 << ADDR_WIDTH)) begin : g_tn_check
        $error("matrix_loader: Tn*Tn does not fit in ADDR_WIDTH address bits");
    end

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX   = ADDR_WIDTH'(Tn * Tn - 1);
    localparam logic [DATA_WIDTH-1:0] ZERO_DATA  = '0;
    localparam logic [ADDR_WIDTH-1:0] ZERO_ADDR  = '0;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_X = 3'd1,
        S_LOAD_Y = 3'd2,
        S_START  = 3'd3,
        S_WAIT   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

    // Element index control shared by the linear counter and, when enabled,
    // the row/column counters used for the transposed Y address.
    logic                  idx_clr;
    logic                  idx_inc;

    logic [ADDR_WIDTH-1:0] y_addr_map;

    logic                  busy;
    logic                  done;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] x_din;
    logic [ADDR_WIDTH-1:0] x_addr;
    logic                  x_wr_en;
    logic [DATA_WIDTH-1:0] y_din;
    logic [ADDR_WIDTH-1:0] y_addr;
    logic                  y_wr_en;
    logic                  mm_start;

    // -------------------------------------------------------------------------
    // State and element counter registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (idx_clr) begin
            cnt_d = '0;
        end else if (idx_inc) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // -------------------------------------------------------------------------
    // Y address mapping
    // -------------------------------------------------------------------------
`ifdef MATRIX_LOADER_TRANSPOSE_Y_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_COL = ADDR_WIDTH'(Tn - 1);
    localparam logic [ADDR_WIDTH-1:0] TN_A     = ADDR_WIDTH'(Tn);

    // Row/column counters track the same element index as cnt_q so the
    // transposed address needs only a constant multiply, no divider.
    logic [ADDR_WIDTH-1:0] row_q, row_d;
    logic [ADDR_WIDTH-1:0] col_q, col_d;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_q <= '0;
            col_q <= '0;
        end else begin
            row_q <= row_d;
            col_q <= col_d;
        end
    end

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (idx_clr) begin
            row_d = '0;
            col_d = '0;
        end else if (idx_inc) begin
            if (col_q == LAST_COL) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end
        end
    end

    assign y_addr_map = col_q * TN_A + row_q;
`else
    assign y_addr_map = cnt_q;
`endif

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        idx_clr  = 1'b0;
        idx_inc  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        in_ready = 1'b0;
        x_din    = ZERO_DATA;
        x_addr   = ZERO_ADDR;
        x_wr_en  = 1'b0;
        y_din    = ZERO_DATA;
        y_addr   = ZERO_ADDR;
        y_wr_en  = 1'b0;
        mm_start = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.load_start) begin
                    state_d = S_LOAD_X;
                    idx_clr = 1'b1;
                end
            end

            S_LOAD_X: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    x_wr_en = 1'b1;
                    x_din   = bus.in_data;
                    x_addr  = cnt_q;
                    if (cnt_q == LAST_IDX) begin
                        // Y phase starts on the very next cycle, no bubble.
                        idx_clr = 1'b1;
                        state_d = S_LOAD_Y;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end

            S_LOAD_Y: begin
                busy     = 1'b1;
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    y_wr_en = 1'b1;
                    y_din   = bus.in_data;
                    y_addr  = y_addr_map;
                    if (cnt_q == LAST_IDX) begin
                        idx_clr = 1'b1;
                        state_d = S_START;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end

            S_START: begin
                busy     = 1'b1;
                mm_start = 1'b1;
                state_d  = S_WAIT;
            end

            S_WAIT: begin
                busy = 1'b1;
                if (bus.mm_done) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.in_ready = in_ready;
    assign bus.x_din    = x_din;
    assign bus.x_addr   = x_addr;
    assign bus.x_wr_en  = x_wr_en;
    assign bus.y_din    = y_din;
    assign bus.y_addr   = y_addr;
    assign bus.y_wr_en  = y_wr_en;
    assign bus.mm_start = mm_start;

endmodule

// File: tb/tb_matrix_loader.sv
module tb_matrix_loader;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int TN = 8;
    localparam int NW = TN * TN;

    logic clock = 1'b0;
    logic reset = 1'b1;

    matrix_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    matrix_loader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .Tn(TN)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    logic [DW-1:0] x_mem [NW];
    logic [DW-1:0] y_mem [NW];
    int x_wc [NW];
    int y_wc [NW];
    int x_total, y_total, mm_cnt, done_cnt, mm_cyc, done_cyc;
    int first_x_addr, y_idx1_addr, quiet_bad;
    bit clr_req = 1'b1;
    logic [DW-1:0] y_idx1_val = '0;

    always @(negedge clock) begin
        if (clr_req) begin
            for (int i = 0; i < NW; i++) begin
                x_mem[i] = '0;
                y_mem[i] = '0;
                x_wc[i]  = 0;
                y_wc[i]  = 0;
            end
            x_total      = 0;
            y_total      = 0;
            mm_cnt       = 0;
            done_cnt     = 0;
            mm_cyc       = -1;
            done_cyc     = -1;
            first_x_addr = -1;
            y_idx1_addr  = -1;
            quiet_bad    = 0;
        end else begin
            if (bus.x_wr_en) begin
                if (x_total == 0) first_x_addr = int'(bus.x_addr);
                x_mem[bus.x_addr] = bus.x_din;
                x_wc[bus.x_addr]++;
                x_total++;
            end else if (bus.x_addr != '0 || bus.x_din != '0) begin
                quiet_bad++;
            end
            if (bus.y_wr_en) begin
                if (bus.y_din == y_idx1_val) y_idx1_addr = int'(bus.y_addr);
                y_mem[bus.y_addr] = bus.y_din;
                y_wc[bus.y_addr]++;
                y_total++;
            end else if (bus.y_addr != '0 || bus.y_din != '0) begin
                quiet_bad++;
            end
            if (bus.mm_start) begin
                mm_cnt++;
                mm_cyc = cyc;
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    // ------------------------------------------------------------------ model
    function automatic int y_map(input int j);
`ifdef MATRIX_LOADER_TRANSPOSE_Y_EN
        return (j % TN) * TN + (j / TN);
`else
        return j;
`endif
    endfunction

    // ----------------------------------------------------------------- driver
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_mon();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
    endtask

    task automatic start_load(output int ls);
        bus.load_start = 1'b1;
        ls = cyc;
        tick();
        bus.load_start = 1'b0;
    endtask

    task automatic feed(input int n, input int base, input bit gap, input bit noise,
                        output int drops, output int ok);
        int  i  = 0;
        int  it = 0;
        bit  v  = 1'b1;
        bit  acc;
        drops = 0;
        while (i < n && it < 4 * n + 20) begin
            bus.in_valid = gap ? v : 1'b1;
            bus.in_data  = DW'(base + i);
            bus.mm_done  = noise && (i < NW) && (it % 3 == 0);
            if (!bus.in_ready) drops++;
            acc = bus.in_valid && bus.in_ready;
            tick();
            if (acc) i++;
            v = !v;
            it++;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.mm_done  = 1'b0;
        ok = (i == n) ? 1 : 0;
    endtask

    // Wait for mm_start, raise mm_done 10 cycles later, then wait for done.
    task automatic finish_op(input bit hold_ls, output int ok);
        int it = 0;
        ok = 0;
        while (mm_cnt == 0 && it < 300) begin
            tick();
            it++;
        end
        if (mm_cnt == 0) return;
        bus.load_start = hold_ls;
        while (cyc < mm_cyc + 10 && it < 600) begin
            tick();
            it++;
        end
        bus.load_start = 1'b0;
        bus.mm_done    = 1'b1;
        tick();
        bus.mm_done    = 1'b0;
        it = 0;
        while (done_cnt == 0 && it < 50) begin
            tick();
            it++;
        end
        ok = (done_cnt != 0) ? 1 : 0;
    endtask

    task automatic check_mem(input string tag, input int base);
        int xerr = 0;
        int yerr = 0;
        for (int i = 0; i < NW; i++) begin
            if (x_mem[i] !== DW'(base + i) || x_wc[i] != 1) xerr++;
            if (y_mem[y_map(i)] !== DW'(base + NW + i) || y_wc[y_map(i)] != 1) yerr++;
        end
        check({tag, " x words"}, x_total, NW);
        check({tag, " y words"}, y_total, NW);
        check({tag, " x data/addr errors"}, xerr, 0);
        check({tag, " y data/addr errors"}, yerr, 0);
    endtask

    // ------------------------------------------------------------------- main
    initial begin
        int ls, drops, ok, fin;

        bus.load_start = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.mm_done    = 1'b0;
        reset          = 1'b1;
        repeat (3) tick();

        check("rst busy",     bus.busy,     0);
        check("rst done",     bus.done,     0);
        check("rst in_ready", bus.in_ready, 0);
        check("rst mm_start", bus.mm_start, 0);
        check("rst x_wr_en",  bus.x_wr_en,  0);
        check("rst y_wr_en",  bus.y_wr_en,  0);

        reset   = 1'b0;
        clr_req = 1'b0;
        tick();
        check("idle busy", bus.busy, 0);

        // Test 1: continuous stream, data 1..128
        y_idx1_val = DW'(1 + NW + 1);
        start_load(ls);
        feed(2 * NW, 1, 1'b0, 1'b0, drops, ok);
        check("t1 all words accepted", ok, 1);
        check("t1 ready drops", drops, 0);
        finish_op(1'b0, fin);
        check("t1 op finished", fin, 1);
        check("t1 mm_start offset", mm_cyc - ls, 2 * NW + 1);
        check("t1 mm_start pulses", mm_cnt, 1);
        check("t1 done after mm_start", done_cyc - mm_cyc, 11);
        check("t1 done pulses", done_cnt, 1);
        check("t1 busy after done", bus.busy, 0);
        check("t1 in_ready after done", bus.in_ready, 0);
`ifdef MATRIX_LOADER_TRANSPOSE_Y_EN
        check("t1 y index1 addr", y_idx1_addr, 8);
`else
        check("t1 y index1 addr", y_idx1_addr, 1);
`endif
        check_mem("t1", 1);
        check("t1 idle ports quiet", quiet_bad, 0);

        // Test 2: in_valid toggling, mm_done noise in LOAD_X, load_start held in WAIT
        clear_mon();
        y_idx1_val = DW'(200 + NW + 1);
        start_load(ls);
        feed(2 * NW, 200, 1'b1, 1'b1, drops, ok);
        check("t2 all words accepted", ok, 1);
        check("t2 ready drops", drops, 0);
        check("t2 no early mm_start", mm_cnt, 0);
        finish_op(1'b1, fin);
        check("t2 op finished", fin, 1);
        check("t2 mm_start offset", mm_cyc - ls, 4 * NW);
        check("t2 mm_start pulses", mm_cnt, 1);
        check("t2 busy after done", bus.busy, 0);
        check_mem("t2", 200);
        repeat (5) tick();
        check("t2 no restart from held load_start", x_total, NW);
        check("t2 done pulses", done_cnt, 1);
        check("t2 idle ports quiet", quiet_bad, 0);

        // Test 3: reset after 20 accepted words, then a clean reload
        clear_mon();
        start_load(ls);
        feed(20, 300, 1'b0, 1'b0, drops, ok);
        check("t3 20 words accepted", ok, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = DW'(999);
        #2;
        reset = 1'b1;
        #1;
        check("t3 rst busy",     bus.busy,     0);
        check("t3 rst in_ready", bus.in_ready, 0);
        check("t3 rst x_wr_en",  bus.x_wr_en,  0);
        check("t3 rst x_din",    bus.x_din,    0);
        tick();
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        reset        = 1'b0;
        repeat (5) tick();
        check("t3 writes after abort", x_total + y_total, 20);
        check("t3 mm_start after abort", mm_cnt, 0);
        check("t3 done after abort", done_cnt, 0);

        clear_mon();
        y_idx1_val = DW'(500 + NW + 1);
        start_load(ls);
        feed(2 * NW, 500, 1'b0, 1'b0, drops, ok);
        check("t3 reload accepted", ok, 1);
        check("t3 reload first x addr", first_x_addr, 0);
        finish_op(1'b0, fin);
        check("t3 reload finished", fin, 1);
        check_mem("t3 reload", 500);
        check("t3 reload done pulses", done_cnt, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
